commit_monitor: RTL and testbench
=================================

Name: commit_monitor

Overview:
Parametrised successor to the single-channel writeback ebreak monitor. Watches NR_COMMIT in-order retire channels from the LS/WB stage and keeps cycle and retired-instruction counters. Detects the ebreak trap and derives a good/bad exit code from a0. A no-retire watchdog catches hangs. Sits beside the core top as a simulation/debug block that drives the end-of-run halt.

Parameters:
NR_COMMIT, 1, number of retire channels (1..4); channel 0 is oldest in program order
DATA_LEN, 32, width of pc and a0 fields
CNT_W, 64, width of the cycle and instret counters
TIMEOUT, 4096, cycles with no retire before watchdog halt; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
commit_valid  in  NR_COMMIT  per-channel retire strobe (LS_WB_reg_ls_valid equivalent)
commit_ebreak  in  NR_COMMIT  retiring instruction is ebreak
commit_pc  in  NR_COMMIT*DATA_LEN  retiring pc; channel i at [i*DATA_LEN +: DATA_LEN]
commit_a0  in  NR_COMMIT*DATA_LEN  architectural a0 value visible to channel i
halt_valid  out  1  1-cycle pulse when the monitor enters HALT
halt_code  out  8  exit code: 0 good trap, 1 bad trap, 2 watchdog
halt_pc  out  DATA_LEN  pc of the ebreak, or last retired pc on watchdog
halted  out  1  level, high while in HALT
cycle_cnt  out  CNT_W  cycles counted in RUN
instret_cnt  out  CNT_W  instructions retired in RUN

Behaviour:
- Reset, with rst sampled on a clk edge: state=RUN; all outputs 0; watchdog counter 0; last_pc 0. Reset has priority over every event and returns a HALT monitor to RUN.
- States: RUN and HALT only. HALT is absorbing until rst.
- RUN, per cycle:
  - cycle_cnt += 1.
  - k = lowest index with commit_valid[k] & commit_ebreak[k].
  - No such k: instret_cnt += popcount(commit_valid).
  - k exists: instret_cnt += popcount(commit_valid[k:0]). Valid channels above k are ignored and not counted.
- Ebreak at channel k moves to HALT at the next edge:
  - halt_code = (commit_a0[k]==0) ? 0 : 1.
  - halt_pc = commit_pc[k].
  - halt_valid high for exactly that one cycle.
- last_pc is updated to the pc of the highest-index counted valid channel.
- Watchdog, when TIMEOUT>0:
  - Counter clears on any cycle with commit_valid!=0; otherwise it increments.
  - When it reaches TIMEOUT-1 and the current cycle has no retire: move to HALT with halt_code=2 and halt_pc=last_pc.
  - An ebreak in the same cycle is impossible, because an ebreak cycle is a retire cycle.
- HALT: counters, halt_code and halt_pc are frozen; inputs are ignored; halt_valid=0; halted=1.
- Counters wrap modulo 2^CNT_W with no saturation.
- Latency: all outputs are registered and reflect the previous cycle's inputs.

Optional Feature:
COMMIT_MONITOR_DPI_HALT_EN
- Defined: the block imports DPI function halt(byte code). On the clk edge where halted rises, it calls halt(halt_code value being registered), once per run.
- Not defined: no DPI import. The block is pure synthesizable RTL and the testbench polls halt_valid/halted.

Test Plan:
- NR_COMMIT=1: 5 cycles of valid, then ebreak with a0=0 -> halt_valid pulse, halt_code=0, instret_cnt=6, halt_pc=ebreak pc, halted stays 1.
- NR_COMMIT=2: valid=2'b11 with ebreak on ch0 and a0=5 -> halt_code=1, instret increments by 1 only, ch1 ignored.
- NR_COMMIT=4, valid=4'b1111 for 3 cycles, no ebreak -> instret_cnt=12, cycle_cnt=3.
- TIMEOUT=16: one retire at pc 0x80000010, then no retires -> HALT exactly 16 cycles after the retire, halt_code=2, halt_pc=0x80000010.
- TIMEOUT=0: 10000 idle cycles -> never halts; cycle_cnt=10000.
- rst asserted 1 cycle while halted -> next cycle RUN, all counters 0, halted=0; a fresh ebreak halts again.

Source files
------------

// File: rtl/commit_monitor.sv
// commit_monitor: multi-channel retire monitor with ebreak trap, counters and no-retire watchdog.
module commit_monitor #(
  parameter int NR_COMMIT = 1,
  parameter int DATA_LEN = 32,
  parameter int CNT_W = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic [NR_COMMIT-1:0] commit_valid,
  input  logic [NR_COMMIT-1:0] commit_ebreak,
  input  logic [NR_COMMIT*DATA_LEN-1:0] commit_pc,
  input  logic [NR_COMMIT*DATA_LEN-1:0] commit_a0,
  output logic halt_valid,
  output logic [7:0] halt_code,
  output logic [DATA_LEN-1:0] halt_pc,
  output logic halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  localparam int CW = $clog2(NR_COMMIT + 1);
  localparam int WD_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic found, wd_fire;
  logic [DATA_LEN-1:0] eb_pc, eb_a0, lpc, last_pc, pc_n;
  logic [WD_W-1:0] wd;
  logic [7:0] code_n;
  assign halted = state == HALT;
  always_comb begin
    found = 1'b0;
    cnt = '0;
    eb_pc = '0;
    eb_a0 = '0;
    lpc = last_pc;
    for (int i = 0; i < NR_COMMIT; i++)
      if (!found && commit_valid[i]) begin
        cnt = cnt + 1'b1;
        lpc = commit_pc[i*DATA_LEN +: DATA_LEN];
        if (commit_ebreak[i]) begin
          found = 1'b1;
          eb_pc = commit_pc[i*DATA_LEN +: DATA_LEN];
          eb_a0 = commit_a0[i*DATA_LEN +: DATA_LEN];
        end
      end
    wd_fire = TIMEOUT > 0 && commit_valid == '0 && wd == WD_W'(TIMEOUT - 1);
    state_n = (state == RUN && (found || wd_fire)) ? HALT : state;
    code_n = found ? {7'd0, eb_a0 != '0} : 8'd2;
    pc_n = found ? eb_pc : last_pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      halt_valid <= 1'b0;
      halt_code <= '0;
      halt_pc <= '0;
      cycle_cnt <= '0;
      instret_cnt <= '0;
      wd <= '0;
      last_pc <= '0;
    end else begin
      state <= state_n;
      halt_valid <= state == RUN && state_n == HALT;
      if (state == RUN) begin
        cycle_cnt <= cycle_cnt + 1'b1;
        instret_cnt <= instret_cnt + CNT_W'(cnt);
        last_pc <= lpc;
        wd <= commit_valid != '0 ? '0 : wd + 1'b1;
        if (state_n == HALT) begin
          halt_code <= code_n;
          halt_pc <= pc_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_commit_monitor.sv
// tb_commit_monitor: directed and randomized checks of commit_monitor against a cycle-level model.
module tb_commit_monitor;
  localparam int TO = 16;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [3:0] v = '0, eb = '0;
  logic [127:0] pc = '0, a0 = '0;
  logic hv, hd;
  logic [7:0] hc;
  logic [31:0] hp;
  logic [63:0] cc, ic;
  logic v2 = 0, eb2 = 0;
  logic [31:0] pc2 = '0, a02 = '0;
  logic hv2, hd2;
  logic [7:0] hc2;
  logic [31:0] hp2;
  logic [15:0] cc2, ic2;
  int tests = 0, fails = 0;
  logic m_hd, m_hv;
  logic [7:0] m_hc;
  logic [31:0] m_hp, m_last;
  logic [63:0] m_cc, m_ic;
  int m_idle;

  commit_monitor #(.NR_COMMIT(4), .DATA_LEN(32), .CNT_W(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .commit_valid(v), .commit_ebreak(eb), .commit_pc(pc), .commit_a0(a0),
    .halt_valid(hv), .halt_code(hc), .halt_pc(hp), .halted(hd), .cycle_cnt(cc), .instret_cnt(ic));

  commit_monitor #(.NR_COMMIT(1), .DATA_LEN(32), .CNT_W(16), .TIMEOUT(0)) dut2 (
    .clk(clk), .rst(rst), .commit_valid(v2), .commit_ebreak(eb2), .commit_pc(pc2), .commit_a0(a02),
    .halt_valid(hv2), .halt_code(hc2), .halt_pc(hp2), .halted(hd2), .cycle_cnt(cc2), .instret_cnt(ic2));

  // Reference for the 4-channel instance: counts consecutive idle cycles directly.
  task automatic model_step();
    int n;
    logic hit;
    n = 0;
    hit = 0;
    m_hv = 0;
    if (rst) begin
      m_hd = 0; m_hc = 0; m_hp = 0; m_last = 0; m_cc = 0; m_ic = 0; m_idle = 0;
    end else if (!m_hd) begin
      m_cc++;
      for (int i = 0; i < 4 && !hit; i++)
        if (v[i]) begin
          n++;
          m_last = pc[i*32 +: 32];
          if (eb[i]) begin
            hit = 1; m_hd = 1; m_hv = 1;
            m_hc = (a0[i*32 +: 32] == 0) ? 8'd0 : 8'd1;
            m_hp = pc[i*32 +: 32];
          end
        end
      m_ic += 64'(n);
      m_idle = (v == 0) ? m_idle + 1 : 0;
      if (m_idle == TO) begin
        m_hd = 1; m_hv = 1; m_hc = 2; m_hp = m_last;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; v = 0; eb = 0; v2 = 0; eb2 = 0;
    cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; v = 4'hf; eb = 4'hf; v2 = 1; eb2 = 1;
    cycle();
    rst = 0; v = 0; eb = 0; v2 = 0; eb2 = 0;
    tests++;
    if ({hv, hc, hp, hd, cc, ic} !== '0) begin
      fails++; $display("FAIL reset4: got hv=%0d hc=%0d hp=%h hd=%0d cc=%0d ic=%0d want all 0", hv, hc, hp, hd, cc, ic);
    end
    tests++;
    if ({hv2, hc2, hp2, hd2, cc2, ic2} !== '0) begin
      fails++; $display("FAIL reset1: got hv=%0d hc=%0d hp=%h hd=%0d cc=%0d ic=%0d want all 0", hv2, hc2, hp2, hd2, cc2, ic2);
    end
  endtask

  task automatic test_single();
    do_reset();
    v2 = 1;
    for (int i = 0; i < 5; i++) begin
      pc2 = 32'h100 + 32'(4 * i);
      cycle();
    end
    eb2 = 1; pc2 = 32'h200; a02 = 0;
    cycle();
    tests++;
    if ({hv2, hc2, hp2, ic2, cc2} !== {1'b1, 8'd0, 32'h200, 16'd6, 16'd6}) begin
      fails++; $display("FAIL single_ebreak: got hv=%0d hc=%0d hp=%h ic=%0d cc=%0d want 1 0 200 6 6", hv2, hc2, hp2, ic2, cc2);
    end
    eb2 = 0; pc2 = 32'h300;
    repeat (3) cycle();
    tests++;
    if ({hv2, hd2, hc2, hp2, ic2, cc2} !== {1'b0, 1'b1, 8'd0, 32'h200, 16'd6, 16'd6}) begin
      fails++; $display("FAIL single_frozen: got hv=%0d hd=%0d hc=%0d hp=%h ic=%0d cc=%0d want 0 1 0 200 6 6", hv2, hd2, hc2, hp2, ic2, cc2);
    end
    v2 = 0;
  endtask

  task automatic test_ch_ignore();
    do_reset();
    v = 4'b0011; eb = 4'b0001;
    pc[31:0] = 32'h80; a0[31:0] = 5; pc[63:32] = 32'h84; a0[63:32] = 0;
    cycle();
    v = 0; eb = 0;
    tests++;
    if ({hv, hc, hp, ic, cc} !== {1'b1, 8'd1, 32'h80, 64'd1, 64'd1}) begin
      fails++; $display("FAIL ch0_bad_trap: got hv=%0d hc=%0d hp=%h ic=%0d cc=%0d want 1 1 80 1 1", hv, hc, hp, ic, cc);
    end
    do_reset();
    v = 4'b0101; eb = 4'b1010;
    cycle();
    tests++;
    if ({hd, ic} !== {1'b0, 64'd2}) begin
      fails++; $display("FAIL invalid_ebreak: got hd=%0d ic=%0d want 0 2", hd, ic);
    end
    v = 4'b1111; eb = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      pc[i*32 +: 32] = 32'h1000 + 32'(i * 4);
      a0[i*32 +: 32] = (i == 2) ? 32'd0 : 32'd9;
    end
    cycle();
    v = 0; eb = 0;
    tests++;
    if ({hv, hc, hp, ic, cc} !== {1'b1, 8'd0, 32'h1008, 64'd5, 64'd2}) begin
      fails++; $display("FAIL ch2_good_trap: got hv=%0d hc=%0d hp=%h ic=%0d cc=%0d want 1 0 1008 5 2", hv, hc, hp, ic, cc);
    end
  endtask

  task automatic test_full_width();
    do_reset();
    v = 4'b1111;
    repeat (3) cycle();
    v = 0;
    tests++;
    if ({hd, ic, cc} !== {1'b0, 64'd12, 64'd3}) begin
      fails++; $display("FAIL full_width: got hd=%0d ic=%0d cc=%0d want 0 12 3", hd, ic, cc);
    end
  endtask

  task automatic test_watchdog();
    logic early;
    early = 0;
    do_reset();
    v = 4'b0001; pc[31:0] = 32'h80000010;
    cycle();
    v = 0;
    repeat (TO - 1) begin
      cycle();
      early |= hd;
    end
    tests++;
    if (early !== 1'b0) begin
      fails++; $display("FAIL watchdog_early: got halted=%0d before %0d idle cycles want 0", early, TO);
    end
    cycle();
    tests++;
    if ({hv, hd, hc, hp, cc, ic} !== {1'b1, 1'b1, 8'd2, 32'h80000010, 64'd17, 64'd1}) begin
      fails++; $display("FAIL watchdog_fire: got hv=%0d hd=%0d hc=%0d hp=%h cc=%0d ic=%0d want 1 1 2 80000010 17 1", hv, hd, hc, hp, cc, ic);
    end
    v = 4'hf; eb = 4'hf;
    repeat (2) cycle();
    v = 0; eb = 0;
    tests++;
    if ({hv, hd, hc, hp, cc, ic} !== {1'b0, 1'b1, 8'd2, 32'h80000010, 64'd17, 64'd1}) begin
      fails++; $display("FAIL halt_frozen: got hv=%0d hd=%0d hc=%0d hp=%h cc=%0d ic=%0d want 0 1 2 80000010 17 1", hv, hd, hc, hp, cc, ic);
    end
  endtask

  task automatic test_reset_from_halt();
    rst = 1;
    cycle();
    rst = 0;
    tests++;
    if ({hv, hc, hp, hd, cc, ic} !== '0) begin
      fails++; $display("FAIL rehalt_reset: got hv=%0d hc=%0d hp=%h hd=%0d cc=%0d ic=%0d want all 0", hv, hc, hp, hd, cc, ic);
    end
    v = 4'b0001; eb = 4'b0001; pc[31:0] = 32'h1234; a0[31:0] = 0;
    cycle();
    v = 0; eb = 0;
    tests++;
    if ({hv, hd, hc, hp, cc, ic} !== {1'b1, 1'b1, 8'd0, 32'h1234, 64'd1, 64'd1}) begin
      fails++; $display("FAIL rehalt_ebreak: got hv=%0d hd=%0d hc=%0d hp=%h cc=%0d ic=%0d want 1 1 0 1234 1 1", hv, hd, hc, hp, cc, ic);
    end
  endtask

  task automatic test_no_timeout();
    logic any;
    any = 0;
    do_reset();
    repeat (10000) begin
      cycle();
      any |= hd2;
    end
    tests++;
    if ({any, cc2, ic2} !== {1'b0, 16'd10000, 16'd0}) begin
      fails++; $display("FAIL no_timeout: got halted=%0d cc=%0d ic=%0d want 0 10000 0", any, cc2, ic2);
    end
  endtask

  task automatic test_random();
    int dens;
    dens = 1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) dens = $urandom_range(0, 3);
      rst = m_hd && $urandom_range(0, 3) == 0;
      v = (dens == 0) ? 4'd0 : 4'($urandom);
      if (dens == 1) v = v & 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        eb[i] = $urandom_range(0, 39) == 0;
        pc[i*32 +: 32] = $urandom;
        a0[i*32 +: 32] = $urandom_range(0, 1) ? 32'd0 : 32'($urandom);
      end
      cycle();
      tests++;
      if ({hv, hc, hp, hd, cc, ic} !== {m_hv, m_hc, m_hp, m_hd, m_cc, m_ic}) begin
        fails++;
        $display("FAIL random@%0d: got hv=%0d hc=%0d hp=%h hd=%0d cc=%0d ic=%0d want hv=%0d hc=%0d hp=%h hd=%0d cc=%0d ic=%0d",
                 c, hv, hc, hp, hd, cc, ic, m_hv, m_hc, m_hp, m_hd, m_cc, m_ic);
      end
    end
    rst = 0; v = 0; eb = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_ch_ignore();
    test_full_width();
    test_watchdog();
    test_reset_from_halt();
    test_no_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
